notch_filter_mc: RTL and testbench
==================================

// Module: notch_filter_mc
// PURPOSE
// - Parametrised multi-channel adaptive IIR notch; NUM_CH channels share one registered multiplier, time-multiplexed.
// - Per channel: s=x+r*a*s1-r2*s2; y=s-a*s1+s2; a+=(y*s1)>>>K. Notch tracks the dominant tone.
// - Sits between sample source and downstream DSP; one sample_trig converts all channels and ends with one filter_done pulse.
// PARAMETERS
// - NUM_CH    1           channel count (>=1)
// - DATA_W    25          signed sample width
// - COEF_SIZE 31          signed coef width, Q2.(COEF_SIZE-2); COEF_FRAC=COEF_SIZE-2
// - GUARD     4           extra MSBs on recursive state s
// - A         1054722904  reset value of a (~2cos(w0)), all channels
// - R         536334041   pole radius r, Q2.COEF_FRAC
// - R2        535797707   r^2, Q2.COEF_FRAC
// - MU_SHIFT  8           step size 2^-MU_SHIFT; K=2*(DATA_W-1)-COEF_FRAC+MU_SHIFT, must be >=0
// PORTS
// - clk          in   1              clock, rising edge
// - reset        in   1              synchronous, active-high
// - sample_trig  in   1              start; sampled only in IDLE
// - adapt_en     in   1              1: update a; 0: a frozen. Sampled at UPD
// - data_in      in   NUM_CH*DATA_W  packed; ch i at [i*DATA_W +: DATA_W]; captured on accepted trig
// - data_out     out  NUM_CH*DATA_W  packed y per channel; held between runs
// - filter_done  out  1              1-cycle pulse: all channels done, data_out valid
// - busy         out  1              1 whenever FSM not IDLE
// - overrun      out  1              sticky; trig seen while busy. Cleared only by reset
// BEHAVIOUR
// - Reset (any cycle, incl. mid-run): FSM->IDLE; data_out=0, filter_done=0, busy=0, overrun=0; all s1/s2=0, all a=A. Partial run discarded, no done.
// - FSM: IDLE -> RA -> S1 -> S2 -> SN -> AY -> GR -> UPD -> (ch<NUM_CH-1 ? ch++, RA : DONE) -> IDLE.
// -   RA: p=r*a. S1: p=(ra)*s1. S2: p=r2*s2. SN: s=x+ra_s1-r2_s2.
// -   AY: p=a*s1, y=s-(a*s1)+s2. GR: p=y*s1. UPD: a update, s2<=s1, s1<=s, write y to data_out slot.
// - Latency: trig high in IDLE at edge k -> filter_done high for cycle after edge k+7*NUM_CH+1. busy high from edge k+1 through the DONE cycle.
// - Trig while busy: ignored, overrun<=1. Trig in DONE cycle also ignored, sets overrun.
// - data_out: all slots update in one edge at DONE, so no torn output on read.
// - Arithmetic: coef products >>> COEF_FRAC with floor (arithmetic shift), no rounding. s held in DATA_W+GUARD bits. y formed at full width, then narrowed to DATA_W.
// - a update: a+=(y*s1)>>>K, computed at COEF_SIZE+1 bits, then clamped to [-2^(COEF_SIZE-1), 2^(COEF_SIZE-1)-1]. Always clamped, regardless of macro.
// - adapt_en=0: a unchanged; s/y path identical to the adapting case.
// - Channels independent: no state shared across channels except the multiplier.
// CONFIGURATION
// - Macro NOTCH_SAT_EN.
// -   Defined: s saturates to DATA_W+GUARD range; y saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
// -   Undefined: both wrap (keep low bits, two's complement).
// STRUCTURE
// - Package notch_pkg: FSM state enum; COEF_FRAC and K localparam functions; sat(value, width) function.
// - Sub-module notch_mul: signed A*B with registered product, 1-cycle latency. Sole multiplier.
// - Top holds the FSM, channel counter, per-channel a/s1/s2 register arrays, output register.
// TESTING
// - Reference model: bit-exact C/Python golden model, same shifts/clamps; all outputs compared per run.
// - Reset/idle: after reset -> data_out=0, done=0, busy=0, overrun=0.
// -   Trig with NUM_CH=1 -> done exactly 8 cycles later, busy high 8 cycles.
// - Impulse, adapt_en=0: x=2^20 then zeros -> y(0)=2^20; 64 following outputs match golden model bit-exact.
// - Tracking, adapt_en=1: 0.5-FS sine at w=0.3*pi (a0 set for 0.1*pi) -> after 4000 samples, output power at least 30 dB below input.
// -   Frozen a, same tone -> no attenuation beyond model.
// - Overrun: trig held 3 cycles -> one run only; overrun=1, stays 1 through next runs until reset.
// - Multichannel, NUM_CH=4: distinct tones/impulses per channel -> each slot matches its own single-channel model; done after 29 cycles.
// - Saturation: x=+/-(2^24-1) square wave, r close to 1.
// -   NOTCH_SAT_EN defined: data_out pinned to 2^24-1 / -2^24.
// -   Undefined: wrapped values match model.
// - Reset mid-run: reset at cycle 4 of a run -> no done; state back to A/zeros; next run equals a fresh post-reset run.

Source files
------------

// File: rtl/notch_pkg.sv
// Shared types and helpers for the multi-channel adaptive notch filter.
// Saturating arithmetic is selected in the top by the NOTCH_SAT_EN macro.
package notch_pkg;

   typedef enum logic [3:0] {
      ST_IDLE, ST_RA, ST_S1, ST_S2, ST_SN, ST_AY, ST_GR, ST_UPD, ST_DONE
   } state_e;

   localparam int WIDE_W = 72;
   typedef logic signed [WIDE_W-1:0] wide_t;
   localparam wide_t ONE = wide_t'(1'b1);

   function automatic int coef_frac(input int coef_size);
      return coef_size - 2;
   endfunction

   function automatic int k_shift(input int data_w, input int coef_size, input int mu_shift);
      return 2 * (data_w - 1) - coef_frac(coef_size) + mu_shift;
   endfunction

   // Clamp v into the two's complement range of a width-bit signed number.
   function automatic wide_t sat(input wide_t v, input int width);
      wide_t hi;
      wide_t lo;
      hi = (ONE <<< (width - 1)) - ONE;
      lo = -(ONE <<< (width - 1));
      if (v > hi) begin
         sat = hi;
      end else if (v < lo) begin
         sat = lo;
      end else begin
         sat = v;
      end
   endfunction

endpackage

// File: rtl/notch_mul.sv
// Signed multiplier with a registered product; the only multiplier in the filter.
module notch_mul #(
   parameter int A_W = 32,
   parameter int B_W = 31
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic signed [A_W-1:0]        a_i,
   input  logic signed [B_W-1:0]        b_i,
   output logic signed [A_W+B_W-1:0]    p_o
);

   logic signed [A_W+B_W-1:0] p_q;

   // Product register, one cycle of latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         p_q <= '0;
      end else begin
         p_q <= a_i * b_i;
      end
   end

   assign p_o = p_q;

endmodule

// File: rtl/notch_filter_mc.sv
// Multi-channel adaptive IIR notch sharing one registered multiplier.
// Define NOTCH_SAT_EN to saturate s and y instead of wrapping them.
module notch_filter_mc
   import notch_pkg::*;
#(
   parameter int NUM_CH    = 1,
   parameter int DATA_W    = 25,
   parameter int COEF_SIZE = 31,
   parameter int GUARD     = 4,
   parameter int A         = 32'sd1054722904,
   parameter int R         = 32'sd536334041,
   parameter int R2        = 32'sd535797707,
   parameter int MU_SHIFT  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     sample_trig,
   input  logic                     adapt_en,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   output logic [NUM_CH*DATA_W-1:0] data_out,
   output logic                     filter_done,
   output logic                     busy,
   output logic                     overrun
);

   localparam int CF    = coef_frac(COEF_SIZE);
   localparam int KS    = k_shift(DATA_W, COEF_SIZE, MU_SHIFT);
   localparam int SW    = DATA_W + GUARD;
   localparam int MA_W  = (COEF_SIZE + 1 > DATA_W) ? COEF_SIZE + 1 : DATA_W;
   localparam int MB_W  = (COEF_SIZE > SW) ? COEF_SIZE : SW;
   localparam int P_W   = MA_W + MB_W;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int NSLOT = 1 << CH_W;

   state_e                       state_q;
   logic [CH_W-1:0]              ch_q;
   logic [NUM_CH*DATA_W-1:0]     x_q;
   logic signed [COEF_SIZE-1:0]  a_q    [NSLOT];
   logic signed [SW-1:0]         s1_q   [NSLOT];
   logic signed [SW-1:0]         s2_q   [NSLOT];
   logic signed [DATA_W-1:0]     ybuf_q [NSLOT];
   logic signed [P_W-1:0]        ra_s1_q;
   logic signed [SW-1:0]         s_q;
   logic signed [DATA_W-1:0]     y_q;
   logic [NUM_CH*DATA_W-1:0]     data_out_q;
   logic                         done_q;
   logic                         busy_q;
   logic                         overrun_q;

   logic signed [P_W-1:0]        p_s;
   logic signed [MA_W-1:0]       op_a_s;
   logic signed [MB_W-1:0]       op_b_s;
   logic signed [COEF_SIZE-1:0]  a_cur_s;
   logic signed [SW-1:0]         s1_cur_s;
   logic signed [SW-1:0]         s2_cur_s;
   logic signed [DATA_W-1:0]     x_cur_s;
   logic signed [MA_W-1:0]       ra_s;
   wide_t                        prod_sh_s;
   wide_t                        s_full_s;
   wide_t                        y_full_s;
   logic signed [SW-1:0]         s_nar_s;
   logic signed [DATA_W-1:0]     y_nar_s;
   logic signed [COEF_SIZE:0]    d_nar_s;
   logic signed [COEF_SIZE:0]    a_sum_s;
   logic signed [COEF_SIZE-1:0]  a_new_s;

   notch_mul #(.A_W(MA_W), .B_W(MB_W)) u_mul (
      .clk   (clk),
      .reset (reset),
      .a_i   (op_a_s),
      .b_i   (op_b_s),
      .p_o   (p_s)
   );

   // Per-channel datapath: the product register always holds the previous state's request.
   always_comb begin
      a_cur_s   = a_q[ch_q];
      s1_cur_s  = s1_q[ch_q];
      s2_cur_s  = s2_q[ch_q];
      x_cur_s   = x_q[ch_q*DATA_W +: DATA_W];
      prod_sh_s = wide_t'(p_s) >>> CF;
      ra_s      = prod_sh_s[MA_W-1:0];
      s_full_s  = wide_t'(x_cur_s) + wide_t'(ra_s1_q) - prod_sh_s;
      y_full_s  = wide_t'(s_q) - prod_sh_s + wide_t'(s2_cur_s);
`ifdef NOTCH_SAT_EN
      s_nar_s   = SW'(sat(s_full_s, SW));
      y_nar_s   = DATA_W'(sat(y_full_s, DATA_W));
`else
      s_nar_s   = SW'(s_full_s);
      y_nar_s   = DATA_W'(y_full_s);
`endif
      d_nar_s   = (COEF_SIZE+1)'(wide_t'(p_s) >>> KS);
      a_sum_s   = (COEF_SIZE+1)'(a_cur_s) + d_nar_s;
      a_new_s   = COEF_SIZE'(sat(wide_t'(a_sum_s), COEF_SIZE));
   end

   // Multiplier operand selection for each step of the channel schedule.
   always_comb begin
      op_a_s = '0;
      op_b_s = '0;
      case (state_q)
         ST_RA: begin
            op_a_s = MA_W'(R);
            op_b_s = MB_W'(a_cur_s);
         end
         ST_S1: begin
            op_a_s = ra_s;
            op_b_s = MB_W'(s1_cur_s);
         end
         ST_S2: begin
            op_a_s = MA_W'(R2);
            op_b_s = MB_W'(s2_cur_s);
         end
         ST_AY: begin
            op_a_s = MA_W'(a_cur_s);
            op_b_s = MB_W'(s1_cur_s);
         end
         ST_GR: begin
            op_a_s = MA_W'(y_nar_s);
            op_b_s = MB_W'(s1_cur_s);
         end
         default: begin
            op_a_s = '0;
            op_b_s = '0;
         end
      endcase
   end

   // Sequencer, per-channel state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ch_q       <= '0;
         x_q        <= '0;
         ra_s1_q    <= '0;
         s_q        <= '0;
         y_q        <= '0;
         data_out_q <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < NSLOT; i++) begin
            a_q[i]    <= COEF_SIZE'(A);
            s1_q[i]   <= '0;
            s2_q[i]   <= '0;
            ybuf_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         busy_q <= (state_q != ST_IDLE);
         if (sample_trig && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (sample_trig) begin
                  x_q     <= data_in;
                  ch_q    <= '0;
                  state_q <= ST_RA;
               end
            end
            ST_RA: state_q <= ST_S1;
            ST_S1: state_q <= ST_S2;
            ST_S2: begin
               ra_s1_q <= prod_sh_s[P_W-1:0];
               state_q <= ST_SN;
            end
            ST_SN: begin
               s_q     <= s_nar_s;
               state_q <= ST_AY;
            end
            ST_AY: state_q <= ST_GR;
            ST_GR: begin
               y_q     <= y_nar_s;
               state_q <= ST_UPD;
            end
            ST_UPD: begin
               if (adapt_en) begin
                  a_q[ch_q] <= a_new_s;
               end
               s2_q[ch_q]   <= s1_cur_s;
               s1_q[ch_q]   <= s_q;
               ybuf_q[ch_q] <= y_q;
               if (ch_q == CH_W'(NUM_CH - 1)) begin
                  state_q <= ST_DONE;
               end else begin
                  ch_q    <= ch_q + CH_W'(1);
                  state_q <= ST_RA;
               end
            end
            ST_DONE: begin
               // All slots publish together so a reader never sees a mixed run.
               for (int i = 0; i < NUM_CH; i++) begin
                  data_out_q[i*DATA_W +: DATA_W] <= ybuf_q[i];
               end
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign data_out    = data_out_q;
   assign filter_done = done_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_notch_filter_mc.sv
// Scoreboard bench for notch_filter_mc with two channels and an independent equation-level model.
module tb_notch_filter_mc;

   localparam int     NCH = 2;
   localparam int     DW  = 25;
   localparam int     SWB = 29;
   localparam longint AR  = 1054722904;
   localparam longint RR  = 536334041;
   localparam longint RR2 = 535797707;
   localparam int     LAT = 7 * NCH + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              sample_trig;
   logic              adapt_en;
   logic [NCH*DW-1:0] data_in;
   logic [NCH*DW-1:0] data_out;
   logic              filter_done;
   logic              busy;
   logic              overrun;

   notch_filter_mc #(.NUM_CH(NCH)) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_trig (sample_trig),
      .adapt_en    (adapt_en),
      .data_in     (data_in),
      .data_out    (data_out),
      .filter_done (filter_done),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      string  name;
      longint act;
      longint exp;
   } chk_t;

   chk_t              dq[$];
   logic [NCH*DW-1:0] exp_q[$];
   int                n_cmp  = 0;
   int                n_fail = 0;
   chk_t              mon_c;
   logic [NCH*DW-1:0] mon_e;
   longint            m_a[NCH];
   longint            m_s1[NCH];
   longint            m_s2[NCH];

   function automatic longint sx(input longint v, input int w);
      return (v <<< (64 - w)) >>> (64 - w);
   endfunction

   function automatic longint clampw(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   function automatic longint narrow(input longint v, input int w);
`ifdef NOTCH_SAT_EN
      return clampw(v, w);
`else
      return sx(v, w);
`endif
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_a[c]  = AR;
         m_s1[c] = 0;
         m_s2[c] = 0;
      end
   endfunction

   // One sample per channel straight from the filter equations.
   function automatic logic [NCH*DW-1:0] model_run(input longint xv[NCH], input bit ad);
      logic [NCH*DW-1:0] out;
      out = '0;
      for (int c = 0; c < NCH; c++) begin
         longint ra, ras1, r2s2, s, y, d;
         ra   = (RR * m_a[c]) >>> 29;
         ras1 = (ra * m_s1[c]) >>> 29;
         r2s2 = (RR2 * m_s2[c]) >>> 29;
         s    = narrow(xv[c] + ras1 - r2s2, SWB);
         y    = narrow(s - ((m_a[c] * m_s1[c]) >>> 29) + m_s2[c], DW);
         if (ad) begin
            d      = (y * m_s1[c]) >>> 27;
            m_a[c] = clampw(m_a[c] + d, 31);
         end
         m_s2[c] = m_s1[c];
         m_s1[c] = s;
         out[c*DW +: DW] = y[DW-1:0];
      end
      return out;
   endfunction

   task automatic chk(input string nm, input longint a, input longint e);
      dq.push_back('{nm, a, e});
   endtask

   task automatic prep(input longint x0, input longint x1, input bit ad, input bit expect_run);
      longint xv[NCH];
      xv[0] = x0;
      xv[1] = x1;
      for (int c = 0; c < NCH; c++) data_in[c*DW +: DW] = xv[c][DW-1:0];
      adapt_en = ad;
      if (expect_run) exp_q.push_back(model_run(xv, ad));
   endtask

   task automatic trig_pulse(input int n);
      sample_trig = 1'b1;
      repeat (n) @(posedge clk);
      #1 sample_trig = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (filter_done !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (filter_done !== 1'b1) chk("done_timeout", 0, 1);
   endtask

   task automatic run(input longint x0, input longint x1, input bit ad);
      prep(x0, x1, ad, 1'b1);
      trig_pulse(1);
      wait_done();
   endtask

   // Monitor: drains queued checks and compares every done against the scoreboard.
   always @(negedge clk) begin
      while (dq.size() > 0) begin
         mon_c = dq.pop_front();
         n_cmp++;
         if (mon_c.act !== mon_c.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", mon_c.name, mon_c.act, mon_c.exp);
         end
      end
      if (filter_done === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done at %0t, required no run pending", $time);
         end else begin
            mon_e = exp_q.pop_front();
            for (int c = 0; c < NCH; c++) begin
               n_cmp++;
               if (data_out[c*DW +: DW] !== mon_e[c*DW +: DW]) begin
                  n_fail++;
                  $display("FAIL y_ch%0d: got %0d, required %0d at %0t", c,
                           $signed(data_out[c*DW +: DW]), $signed(mon_e[c*DW +: DW]), $time);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int     done_at, busy_n, done_n;
      longint x0, x1;
      reset       = 1'b1;
      sample_trig = 1'b0;
      adapt_en    = 1'b0;
      data_in     = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_data_out", longint'(data_out), 0);
      chk("rst_done", longint'(filter_done), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_overrun", longint'(overrun), 0);

      // Impulse run that also measures latency and busy width.
      prep(1 << 20, -(3 << 18), 1'b0, 1'b1);
      trig_pulse(1);
      done_at = 0;
      busy_n  = 0;
      done_n  = 0;
      for (int i = 1; i <= LAT + 4; i++) begin
         @(posedge clk);
         #1;
         if (busy === 1'b1) busy_n++;
         if (filter_done === 1'b1) begin
            done_n++;
            if (done_at == 0) done_at = i;
         end
      end
      chk("latency", done_at, LAT);
      chk("busy_cycles", busy_n, LAT);
      chk("done_pulses", done_n, 1);
      chk("impulse_y0_ch0", longint'($signed(data_out[DW-1:0])), 1048576);
      chk("impulse_y0_ch1", longint'($signed(data_out[2*DW-1:DW])), -786432);
      for (int n = 0; n < 30; n++) run(0, 0, 1'b0);
      chk("overrun_clear", longint'(overrun), 0);

      // Trigger held for three cycles: one run, sticky overrun.
      prep(1000, -2000, 1'b0, 1'b1);
      trig_pulse(3);
      wait_done();
      repeat (LAT + 3) @(posedge clk);
      #1 chk("overrun_set", longint'(overrun), 1);
      run(5000, 7, 1'b0);
      chk("overrun_sticky", longint'(overrun), 1);

      // Reset four cycles into a run: no done, state back to reset values.
      prep(123456, -654321, 1'b0, 1'b0);
      trig_pulse(1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      done_n = 0;
      for (int i = 0; i < LAT + 4; i++) begin
         @(posedge clk);
         #1;
         if (filter_done === 1'b1) done_n++;
      end
      chk("midrst_done", done_n, 0);
      chk("midrst_overrun", longint'(overrun), 0);
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_data_out", longint'(data_out), 0);
      model_reset();
      run(1 << 20, -(3 << 18), 1'b0);
      chk("fresh_y0_ch0", longint'($signed(data_out[DW-1:0])), 1048576);
      for (int n = 0; n < 5; n++) run(0, 0, 1'b0);

      // Adapting on tones, then frozen on the same tones.
      for (int n = 0; n < 170; n++) begin
         x0 = longint'($rtoi(8388607.0 * $sin(0.3 * 3.141592653589793 * real'(n))));
         x1 = longint'($rtoi(4194303.0 * $sin(0.1 * 3.141592653589793 * real'(n))));
         run(x0, x1, (n < 150) ? 1'b1 : 1'b0);
      end

      // Full-scale square waves.
      for (int n = 0; n < 30; n++) begin
         x0 = (n % 2 == 0) ? 16777215 : -16777215;
         x1 = ((n / 2) % 2 == 0) ? 16777215 : -16777215;
         run(x0, x1, 1'b0);
      end

      repeat (LAT + 3) @(posedge clk);
      #1 chk("sb_empty", longint'(exp_q.size()), 0);
      repeat (3) @(negedge clk);
      #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
